bus_interface: RTL

Parametrised external-bus interface unit, the successor to the fixed 8-bit tri-state bus glue between the core and the pins. It accepts single read/write requests from the core over a req/ack handshake and runs them on a shared bidirectional data bus. Bus cycles stretch for a `ready` input (wait states), are bounded by a timeout, and insert idle turnaround cycles before a write that follows a read. Sits between `core` and the chip-level pads inside the top-level CPU module.

---
 rtl/hmc_bus_pkg.sv | 12 +
 rtl/bus_wait_timer.sv | 28 ++
 rtl/bus_interface.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hmc_bus_pkg.sv
// Shared types and defaults for the external bus interface.
package hmc_bus_pkg;

    localparam int unsigned WAIT_MAX_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        ACCESS = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Loadable saturating counter used for turnaround and wait-state counting.
module bus_wait_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] terminal,
    output logic         done_c
);

    logic [W-1:0] count;

    // Holds at the terminal value so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done_c) begin
            count <= count + W'(1);
        end
    end

    assign done_c = (count == terminal);

endmodule

// File: rtl/bus_interface.sv
// External bus interface: single core requests run on a shared tri-state data
// bus with wait states, timeout and read-to-write turnaround.
module bus_interface
    import hmc_bus_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned WAIT_MAX   = WAIT_MAX_DEFAULT,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    output logic              read_en,
    input  logic              ready
);

    localparam int unsigned TURN_TERM = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
    localparam int unsigned CNT_MAX   = (WAIT_MAX > TURN_TERM) ? WAIT_MAX : TURN_TERM;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    bus_state_t        state;
    bus_state_t        state_d;
    logic              we_q;
    logic              we_next;
    logic [DATA_W-1:0] wdata_q;
    logic              last_read;
    logic              latch;
    logic              capture;
    logic              complete;
    logic              timeout;
    logic              tmr_clear;
    logic              tmr_en;
    logic              tmr_done;
    logic [CNT_W-1:0]  terminal;

    bus_wait_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (ph1),
        .rst_n    (reset),
        .clear    (tmr_clear),
        .enable   (tmr_en),
        .terminal (terminal),
        .done_c   (tmr_done)
    );

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus per-cycle control strobes for the datapath.
    always_comb begin
        state_d   = state;
        latch     = 1'b0;
        capture   = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        terminal  = CNT_W'(WAIT_MAX);
        case (state)
            IDLE: begin
                tmr_clear = 1'b1;
                if (req) begin
                    latch   = 1'b1;
                    state_d = (we && last_read && (TURNAROUND > 0)) ? TURN : ACCESS;
                end
            end
            TURN: begin
                terminal = CNT_W'(TURN_TERM);
                if (tmr_done) begin
                    state_d   = ACCESS;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ACCESS: begin
                if (ready) begin
                    complete = 1'b1;
                    capture  = !we_q;
                    state_d  = IDLE;
                end else if (tmr_done) begin
                    complete = 1'b1;
                    timeout  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        we_next = latch ? we : we_q;
    end

    // Outputs are registered from next-state so they line up with the state.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            address   <= '0;
            read_en   <= 1'b1;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            last_read <= 1'b0;
        end else begin
            ack     <= complete;
            err     <= timeout;
            busy    <= (state_d != IDLE);
            read_en <= !((state_d == ACCESS) && we_next);
            if (latch) begin
                address <= addr;
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (capture) begin
                rdata <= data;
            end
            if (complete) begin
                last_read <= !we_q;
            end
        end
    end

    assign data = read_en ? {DATA_W{1'bz}} : wdata_q;

endmodule
